// File: rtl/gpu_rf_pkg.sv
// ---------------------------------------------------------------------------
// gpu_rf_pkg
//
// Shared constants and helpers for units that front the single-port
// 32 x 64-bit register file.
//
// Contents:
//    RF_DEPTH  - number of architectural registers
//    RF_DW     - register data width
//    RF_RNW    - register index width on the request side
//    RF_IDX_W  - width of the register file index bus
//    next_rr() - round-robin successor of a winning requester ID
// ---------------------------------------------------------------------------
package gpu_rf_pkg;

   localparam int RF_DEPTH = 32;
   localparam int RF_DW    = 64;
   localparam int RF_RNW   = 5;
   localparam int RF_IDX_W = 32;

   // The requester after 'winner' becomes the highest priority. The wrap is
   // written as a compare rather than a modulo, so a requester count that is
   // not a power of two never yields an ID that does not exist.
   function automatic int next_rr(input int winner, input int nreq);
      if (winner >= nreq - 1)
         return 0;
      else
         return winner + 1;
   endfunction

endpackage

// File: rtl/regfile_port_arbiter_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
//
// Combinational round-robin picker. Scans the request vector beginning at
// the priority pointer and wrapping at NREQ, and returns the first active
// request both as a one-hot grant and as an encoded ID. Holds no state, so
// the owner decides when and how the pointer moves.
//
// Ports:
//    req     in   NREQ  request vector
//    ptr     in   IDW   highest-priority requester this cycle (< NREQ)
//    grant   out  NREQ  one-hot grant, zero when no request is active
//    winner  out  IDW   encoded grant, zero when no request is active
//    any     out  1     at least one request is active
// ---------------------------------------------------------------------------
module rr_arbiter #(
   parameter int NREQ = 4,
   parameter int IDW  = 2
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  ptr,
   output logic [NREQ-1:0] grant,
   output logic [IDW-1:0]  winner,
   output logic            any
);

   logic [IDW:0]   scan_sum;
   logic [IDW-1:0] scan_idx;

   // Walk the candidates in priority order ptr, ptr+1, ... modulo NREQ and
   // keep the first one found. The sum carries one extra bit so that
   // ptr + offset cannot overflow before the wrap subtraction; since ptr is
   // always below NREQ, one subtraction is enough to bring it into range.
   always_comb begin
      grant    = '0;
      winner   = '0;
      any      = 1'b0;
      scan_sum = '0;
      scan_idx = '0;
      for (int k = 0; k < NREQ; k++) begin
         scan_sum = {1'b0, ptr} + (IDW+1)'(k);
         if (scan_sum >= (IDW+1)'(NREQ))
            scan_sum = scan_sum - (IDW+1)'(NREQ);
         scan_idx = scan_sum[IDW-1:0];
         if (!any && req[scan_idx]) begin
            any              = 1'b1;
            grant[scan_idx]  = 1'b1;
            winner           = scan_idx;
         end
      end
   end

endmodule

// File: rtl/regfile_port_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_port_arbiter
//
// Shares the single-port register file between NREQ requesters (lane
// execution units, load/store writeback, ...). One request per cycle is
// granted round-robin and driven straight onto the register file port in the
// same cycle. Read data comes back the following cycle on a shared response
// bus tagged with the ID of the requester that issued the read.
//
// Ports:
//    clk              in   1         clock, all state updates on posedge
//    rst              in   1         asynchronous active-high reset
//    req_valid        in   NREQ      per-requester request valid
//    req_ready        out  NREQ      per-requester accept, one-hot or zero
//    req_write        in   NREQ      per-requester op, 1 = write, 0 = read
//    req_reg          in   NREQ*RNW  register index, requester i at [i*RNW +: RNW]
//    req_wdata        in   NREQ*DW   write data, requester i at [i*DW +: DW]
//    rsp_valid        out  1         read data valid this cycle
//    rsp_id           out  IDW       requester that issued the read
//    rsp_data         out  DW        read data
//    rf_register_num  out  32        register file index, zero-extended
//    rf_read          out  1         register file read strobe
//    rf_write         out  1         register file write strobe
//    rf_in            out  DW        register file write data
//    rf_out           in   DW        register file read data, valid the
//                                    cycle after rf_read
// ---------------------------------------------------------------------------
module regfile_port_arbiter
   import gpu_rf_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int IDW  = 2,
   parameter int DW   = RF_DW,
   parameter int RNW  = RF_RNW
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req_valid,
   output logic [NREQ-1:0]       req_ready,
   input  logic [NREQ-1:0]       req_write,
   input  logic [NREQ*RNW-1:0]   req_reg,
   input  logic [NREQ*DW-1:0]    req_wdata,
   output logic                  rsp_valid,
   output logic [IDW-1:0]        rsp_id,
   output logic [DW-1:0]         rsp_data,
   output logic [RF_IDX_W-1:0]   rf_register_num,
   output logic                  rf_read,
   output logic                  rf_write,
   output logic [DW-1:0]         rf_in,
   input  logic [DW-1:0]         rf_out
);

   logic [IDW-1:0]  rr_ptr;
   logic [IDW-1:0]  rd_id;
   logic            rd_pend;

   logic [NREQ-1:0] arb_grant;
   logic [IDW-1:0]  winner;
   logic            any_req;
   logic            grant;

   logic            win_write;
   logic [RNW-1:0]  win_reg;
   logic [DW-1:0]   win_wdata;

   rr_arbiter #(
      .NREQ (NREQ),
      .IDW  (IDW)
   ) u_rr_arbiter (
      .req    (req_valid),
      .ptr    (rr_ptr),
      .grant  (arb_grant),
      .winner (winner),
      .any    (any_req)
   );

   // Reset kills the grant combinationally, so nothing is accepted and no
   // strobe reaches the register file while rst is high, even between edges.
   assign grant     = any_req & ~rst;
   assign req_ready = grant ? arb_grant : '0;

   // Select the winner's fields. Everything is forced to zero without a
   // grant so the register file port sits at a clean idle value rather than
   // echoing whatever requester 0 happens to present.
   always_comb begin
      win_write = 1'b0;
      win_reg   = '0;
      win_wdata = '0;
      if (grant) begin
         win_write = req_write[winner];
         win_reg   = req_reg[int'(winner)*RNW +: RNW];
         win_wdata = req_wdata[int'(winner)*DW +: DW];
      end
   end

   // Drive the register file port in the grant cycle. Only one request is
   // granted, so read and write are mutually exclusive by construction.
   always_comb begin
      rf_register_num = {{(RF_IDX_W-RNW){1'b0}}, win_reg};
      rf_in           = win_wdata;
      rf_write        = grant &  win_write;
      rf_read         = grant & ~win_write;
   end

   // The winner's successor becomes top priority after every grant; with no
   // grant the pointer keeps its place so fairness is not disturbed by idle
   // cycles.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         rr_ptr <= '0;
      else if (grant)
         rr_ptr <= IDW'(next_rr(int'(winner), NREQ));
   end

   // Remember which read went to the register file this cycle; its data
   // shows up on rf_out one cycle later. A read in flight when reset hits is
   // simply forgotten.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_pend <= 1'b0;
         rd_id   <= '0;
      end
      else begin
         rd_pend <= rf_read;
         rd_id   <= winner;
      end
   end

   // The register file output is already registered, so the response is a
   // direct pass-through qualified by the pending flag. There is no
   // backpressure: requesters must always sink responses.
   assign rsp_valid = rd_pend;
   assign rsp_id    = rd_id;
   assign rsp_data  = rf_out;

endmodule

// File: doc/regfile_port_arbiter.md
Name: regfile_port_arbiter

Overview:
- Shares the single-port 32 x 64-bit register file between NREQ requesters, such as lane execution units and the load/store writeback path.
- Each requester issues read or write requests over a valid/ready handshake.
- Round-robin arbitration grants one request per cycle and drives the register file port.
- Read data is returned one cycle later on a shared response bus, tagged with the requester ID.

Parameters:
- NREQ, 4, number of requesters; legal range 2..8.
- IDW, 2, requester ID width; must equal clog2(NREQ).
- DW, 64, data width; matches the register file.
- RNW, 5, register index width used on the request side.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept; one-hot or zero.
- req_write  in  NREQ  per-requester op: 1 = write, 0 = read.
- req_reg  in  NREQ*RNW  register index; requester i occupies bits [i*RNW +: RNW].
- req_wdata  in  NREQ*DW  write data; requester i occupies bits [i*DW +: DW].
- rsp_valid  out  1  read data valid this cycle.
- rsp_id  out  IDW  requester that issued the read.
- rsp_data  out  DW  read data.
- rf_register_num  out  32  register file index; zero-extended from RNW.
- rf_read  out  1  register file read strobe.
- rf_write  out  1  register file write strobe.
- rf_in  out  DW  register file write data.
- rf_out  in  DW  register file read data; registered, valid the cycle after rf_read.

Behaviour:
- State:
  - rr_ptr[IDW]: next highest-priority requester.
  - rd_pend (1 bit) and rd_id[IDW]: the read issued last cycle.
- Grant (combinational):
  - winner = first i with req_valid[i]=1, scanning rr_ptr, rr_ptr+1, ... mod NREQ.
  - req_ready = onehot(winner) when any req_valid is set, else 0.
  - A requester must hold valid and its fields stable until ready is seen. The arbiter does not depend on this but the bench checks it.
- Issue (combinational, same cycle as grant):
  - rf_register_num = {27'b0, req_reg[winner]}.
  - rf_in = req_wdata[winner].
  - rf_write = grant & req_write[winner].
  - rf_read = grant & ~req_write[winner].
  - rf_read and rf_write are never both 1.
  - With no grant: rf_read = rf_write = 0, rf_register_num = 0, rf_in = 0.
- Pointer update at posedge:
  - If grant, rr_ptr <= winner + 1, wrapping NREQ-1 -> 0.
  - If no grant, rr_ptr holds.
  - When NREQ is not a power of two, wrap explicitly; never land on an ID >= NREQ.
- Response:
  - rd_pend <= rf_read; rd_id <= winner.
  - rsp_valid = rd_pend; rsp_id = rd_id; rsp_data = rf_out (pass-through).
  - Read latency: handshake at edge k, rsp_valid=1 during the cycle after edge k.
  - One response per cycle at most. There is no response backpressure; requesters must always sink responses.
  - Writes produce no response. Write data is in the register file after the handshake edge.
- Throughput: one request per cycle, reads and writes mixed back-to-back.
- Ordering and hazards:
  - A read granted in the cycle after a write to the same register returns the new data, because the register file updates at the handshake edge.
  - A read and a write in the same cycle cannot occur (single grant).
- Fairness: with all NREQ valid continuously, each requester is granted exactly once every NREQ cycles.
- Reset:
  - rst asserted (asynchronous): rr_ptr=0, rd_pend=0, rd_id=0.
  - Hence rsp_valid=0 and rsp_id=0.
  - While rst=1: req_ready=0, rf_read=0, rf_write=0 (gated combinationally).
  - A read issued in the cycle before reset has its response dropped, not replayed.
- Out-of-range: RNW=5 covers all 32 registers; no range check is needed.

Decomposition:
- Shared package gpu_rf_pkg holds:
  - RF_DEPTH=32, RF_DW=64, RF_RNW=5, RF_IDX_W=32.
  - The function next_rr(winner, nreq) for wrap arithmetic.
- One sub-module: rr_arbiter (NREQ requests in, rr_ptr in, one-hot grant plus encoded winner out), reusable for later shared units.
- Pointer, response pipeline and muxing live in regfile_port_arbiter.

Test Plan:
- Reset then idle: rst pulse mid-cycle, no req_valid -> all outputs 0 immediately; rr_ptr=0; no rf strobes.
- Single write then read:
  - Requester 2 writes reg 7 = 64'hDEAD_BEEF_0123_4567 (ready same cycle).
  - Next cycle requester 2 reads reg 7.
  - Expect: one cycle later, rsp_valid=1, rsp_id=2, rsp_data=64'hDEAD_BEEF_0123_4567.
- Full contention:
  - All 4 requesters hold valid reads of reg i for 8 cycles.
  - Expect: grants 0,1,2,3,0,1,2,3; responses follow one cycle behind with matching rsp_id and reg data.
- Pointer skip:
  - Only requesters 1 and 3 valid, rr_ptr=2.
  - Expect: grant 3 first, then 1, then 3 (wrap through 0 skipped).
- Write-then-read same reg:
  - Requester 0 writes reg 31=1 in cycle n; requester 1 reads reg 31 in cycle n+1.
  - Expect: rsp_data=1 in cycle n+2; rf_read and rf_write never both high.
- Reset mid-read:
  - Read granted, rst asserted before the next edge.
  - Expect: rsp_valid stays 0; after release the first grant goes to requester 0.
